// File: rtl/fifo_write_arbiter_if.sv
// Bundle of producer handshakes and the FIFO write-side signals shared by the
// write arbiter. The arbiter connects through the slave modport. Producers,
// the FIFO model and a testbench connect through the master modport.
interface fifo_write_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int ID_W = $clog2(NUM_REQ);

    // Producer side: one valid/ready pair per producer, words packed side by side
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;

    // FIFO write side
    logic                          fifo_full;
    logic                          fifo_write;
    logic [DATA_WIDTH-1:0]         fifo_data_write;

    // Status
    logic [ID_W-1:0]               grant_id;
    logic                          busy;

    modport master (
        output req_valid,
        output req_data,
        output fifo_full,
        input  req_ready,
        input  fifo_write,
        input  fifo_data_write,
        input  grant_id,
        input  busy
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  fifo_full,
        output req_ready,
        output fifo_write,
        output fifo_data_write,
        output grant_id,
        output busy
    );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Write-port arbiter for the asynchronous FIFO. NUM_REQ producers in the
// clk_write domain share the single FIFO write port. One producer at a time
// owns the port for a burst of up to BURST_LEN words. The write strobe and
// the write data pass straight through from the owner's handshake, with no
// added latency.
//
// Build option: define FIFO_ARB_FIXED_PRIO_EN to replace round-robin
// selection with fixed priority, where the lowest valid index always wins.
module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 16
) (
    input  logic                clk_write,
    input  logic                rst,
    fifo_write_arbiter_if.slave bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    // Value of burst_cnt when the transfer that completes a burst occurs
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [ID_W-1:0]       grant_id_q;
    logic [ID_W-1:0]       grant_id_d;
    logic [CNT_W-1:0]      burst_cnt_q;
    logic [CNT_W-1:0]      burst_cnt_d;
`ifndef FIFO_ARB_FIXED_PRIO_EN
    logic [ID_W-1:0]       last_grant_q;
    logic [ID_W-1:0]       last_grant_d;
    int                    rr_idx;
    logic                  rr_found;
`endif

    logic                  any_valid;
    logic [ID_W-1:0]       winner;
    logic                  owner_valid;
    logic [DATA_WIDTH-1:0] owner_data;
    logic                  transfer;
    logic                  burst_done;

    assign any_valid = |bus.req_valid;

`ifdef FIFO_ARB_FIXED_PRIO_EN
    // Fixed priority: scan from the top down so the lowest valid index is written last and wins
    always_comb begin
        winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                winner = ID_W'(i);
            end
        end
    end
`else
    // Round-robin: search starts just after the previous winner and takes the first valid index
    always_comb begin
        winner   = '0;
        rr_found = 1'b0;
        rr_idx   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            rr_idx = (int'(last_grant_q) + k) % NUM_REQ;
            if (!rr_found && bus.req_valid[rr_idx]) begin
                winner   = ID_W'(rr_idx);
                rr_found = 1'b1;
            end
        end
    end
`endif

    // Select the current owner's valid bit and data word
    always_comb begin
        owner_valid = 1'b0;
        owner_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id_q == ID_W'(i)) begin
                owner_valid = bus.req_valid[i];
                owner_data  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // A word moves only when the owner offers one and the FIFO has room
    assign transfer   = (state_q == GRANT) && owner_valid && !bus.fifo_full;
    assign burst_done = (burst_cnt_q == LAST_CNT);

    // Next-state logic: grant in IDLE, then count words until burst end or owner release
    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        burst_cnt_d  = burst_cnt_q;
`ifndef FIFO_ARB_FIXED_PRIO_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    state_d      = GRANT;
                    grant_id_d   = winner;
                    burst_cnt_d  = '0;
`ifndef FIFO_ARB_FIXED_PRIO_EN
                    last_grant_d = winner;
`endif
                end
            end
            GRANT: begin
                if (!owner_valid) begin
                    state_d = IDLE;
                end else if (transfer) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                    if (burst_done) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers. Reset makes producer 0 the first round-robin winner.
    always_ff @(posedge clk_write) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_id_q   <= '0;
            burst_cnt_q  <= '0;
`ifndef FIFO_ARB_FIXED_PRIO_EN
            last_grant_q <= ID_W'(NUM_REQ - 1);
`endif
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            burst_cnt_q  <= burst_cnt_d;
`ifndef FIFO_ARB_FIXED_PRIO_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // Handshake and FIFO drive. Reset silences these outputs at once, without waiting for a clock edge.
    always_comb begin
        bus.req_ready       = '0;
        bus.fifo_write      = 1'b0;
        bus.fifo_data_write = '0;
        if (!rst && state_q == GRANT) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                bus.req_ready[i] = (grant_id_q == ID_W'(i)) && !bus.fifo_full;
            end
            bus.fifo_write      = transfer;
            bus.fifo_data_write = owner_data;
        end
    end

    assign bus.grant_id = grant_id_q;
    assign bus.busy     = (state_q == GRANT);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Testbench for fifo_write_arbiter. Producers are modelled as word queues.
// A behavioural owner/word-count model supplies the expected outputs every cycle.
// Directed scenarios are followed by a randomized run.
module tb_fifo_write_arbiter;
    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 8;
    localparam int BURST_LEN  = 4;
    localparam int ID_W       = $clog2(NUM_REQ);

    logic clk_write = 1'b0;
    logic rst;

    // Free-running write clock
    always #5 clk_write = ~clk_write;

    fifo_write_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH)) bus ();

    fifo_write_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DATA_WIDTH),
        .BURST_LEN  (BURST_LEN)
    ) dut (
        .clk_write (clk_write),
        .rst       (rst),
        .bus       (bus)
    );

    int test_count = 0;
    int fail_count = 0;
    int cycle_num  = 0;

    logic [DATA_WIDTH-1:0] prod_q [NUM_REQ][$];
    bit                    offered [NUM_REQ];
    bit                    enable_bits [NUM_REQ];
    bit                    rand_en = 1'b0;
    logic                  full_sig = 1'b0;
    logic                  rst_sig  = 1'b1;

    logic [NUM_REQ-1:0]            drv_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] drv_data;

    bit m_busy;
    int m_owner;
    int m_sent;
    int m_last;

    int write_log [$];
    int write_cyc [$];
    int grant_log [$];
    bit prev_busy = 1'b0;

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        test_count++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus();
        logic [NUM_REQ-1:0]            v;
        logic [NUM_REQ*DATA_WIDTH-1:0] d;
        v = '0;
        d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rand_en && !offered[i]) enable_bits[i] = ($urandom_range(0, 3) != 0);
            if (prod_q[i].size() > 0 && (offered[i] || enable_bits[i])) begin
                v[i] = 1'b1;
                d[i*DATA_WIDTH +: DATA_WIDTH] = prod_q[i][0];
                offered[i] = 1'b1;
            end
        end
        drv_valid     = v;
        drv_data      = d;
        bus.req_valid = v;
        bus.req_data  = d;
        bus.fifo_full = full_sig;
        rst           = rst_sig;
    endtask

    function automatic int pickWinner();
`ifdef FIFO_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NUM_REQ; i++) if (drv_valid[i]) return i;
`else
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (drv_valid[(m_last + k) % NUM_REQ]) return (m_last + k) % NUM_REQ;
        end
`endif
        return -1;
    endfunction

    task automatic modelUpdate();
        int w;
        if (rst_sig) begin
            m_busy  = 1'b0;
            m_owner = 0;
            m_sent  = 0;
            m_last  = NUM_REQ - 1;
        end else if (!m_busy) begin
            w = pickWinner();
            if (w >= 0) begin
                m_busy  = 1'b1;
                m_owner = w;
                m_last  = w;
                m_sent  = 0;
            end
        end else if (!drv_valid[m_owner]) begin
            m_busy = 1'b0;
        end else if (!full_sig) begin
            m_sent++;
            if (m_sent == BURST_LEN) m_busy = 1'b0;
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [NUM_REQ-1:0]    exp_ready;
        logic                  exp_write;
        logic [DATA_WIDTH-1:0] exp_data;
        exp_ready = '0;
        exp_write = 1'b0;
        exp_data  = '0;
        if (!rst_sig && m_busy) begin
            if (!full_sig) exp_ready[m_owner] = 1'b1;
            exp_write = drv_valid[m_owner] && !full_sig;
            exp_data  = drv_data[m_owner*DATA_WIDTH +: DATA_WIDTH];
        end
        checkEq({tag, ".busy"},  32'(bus.busy),            32'(m_busy));
        checkEq({tag, ".grant"}, 32'(bus.grant_id),        32'(m_owner));
        checkEq({tag, ".ready"}, 32'(bus.req_ready),       32'(exp_ready));
        checkEq({tag, ".write"}, 32'(bus.fifo_write),      32'(exp_write));
        checkEq({tag, ".data"},  32'(bus.fifo_data_write), 32'(exp_data));
    endtask

    task automatic tick(input string tag);
        logic [NUM_REQ-1:0] acc;
        @(negedge clk_write);
        checkOutput(tag);
        acc = bus.req_ready & drv_valid;
        if (bus.fifo_write === 1'b1) begin
            write_log.push_back(int'(bus.fifo_data_write));
            write_cyc.push_back(cycle_num);
        end
        if (bus.busy === 1'b1 && !prev_busy) grant_log.push_back(int'(bus.grant_id));
        prev_busy = (bus.busy === 1'b1);
        @(posedge clk_write);
        cycle_num++;
        modelUpdate();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (acc[i]) begin
                void'(prod_q[i].pop_front());
                offered[i] = 1'b0;
            end
        end
        #1;
        applyStimulus();
    endtask

    task automatic clearProducers();
        for (int i = 0; i < NUM_REQ; i++) begin
            prod_q[i].delete();
            offered[i]     = 1'b0;
            enable_bits[i] = 1'b1;
        end
        write_log.delete();
        write_cyc.delete();
        grant_log.delete();
    endtask

    task automatic doReset(input int n);
        rst_sig = 1'b1;
        applyStimulus();
        repeat (n) tick("reset");
        clearProducers();
        rst_sig = 1'b0;
        applyStimulus();
    endtask

    initial begin
        int start;
        int n_before;
        int exp_a [6];
        clearProducers();
        m_busy  = 1'b0;
        m_owner = 0;
        m_sent  = 0;
        m_last  = NUM_REQ - 1;
        rst_sig = 1'b1;
        applyStimulus();
        @(posedge clk_write);
        #1;

        // Reset with every producer offering
        for (int i = 0; i < NUM_REQ; i++) prod_q[i] = '{8'hA0, 8'hA1};
        applyStimulus();
        repeat (3) tick("rst");
        checkEq("rst_write", 32'(bus.fifo_write), 32'd0);
        checkEq("rst_ready", 32'(bus.req_ready), 32'd0);
        checkEq("rst_busy",  32'(bus.busy), 32'd0);
        checkEq("rst_grant", 32'(bus.grant_id), 32'd0);
        clearProducers();
        rst_sig = 1'b0;
        applyStimulus();

        // Single producer, six words: one full burst, bubble, then a short burst
        for (int k = 0; k < 6; k++) prod_q[2].push_back(8'(8'h10 + k));
        applyStimulus();
        start = cycle_num;
        repeat (12) tick("single");
        exp_a = '{1, 2, 3, 4, 6, 7};
        checkEq("single_count", 32'(write_log.size()), 32'd6);
        for (int k = 0; k < 6 && k < write_log.size(); k++) begin
            checkEq("single_word", 32'(write_log[k]), 32'(8'h10 + k));
            checkEq("single_cycle", 32'(write_cyc[k] - start), 32'(exp_a[k]));
        end

        // All producers continuously valid
        doReset(1);
        for (int i = 0; i < NUM_REQ; i++)
            for (int k = 0; k < 8; k++) prod_q[i].push_back(8'(i * 16 + k));
        applyStimulus();
        start = cycle_num;
        repeat (44) tick("rr");
        checkEq("rr_total", 32'(write_log.size()), 32'd32);
`ifndef FIFO_ARB_FIXED_PRIO_EN
        exp_a = '{0, 1, 2, 3, 0, 1};
        checkEq("rr_grants", 32'(grant_log.size()), 32'd8);
        for (int g = 0; g < 6 && g < grant_log.size(); g++)
            checkEq("rr_order", 32'(grant_log[g]), 32'(exp_a[g]));
        for (int k = 0; k < 16 && k < write_log.size(); k++)
            checkEq("rr_word", 32'(write_log[k]), 32'((k / 4) * 16 + (k % 4)));
        if (write_cyc.size() > 16) begin
            checkEq("rr_cyc15", 32'(write_cyc[15] - start), 32'd19);
            checkEq("rr_cyc16", 32'(write_cyc[16] - start), 32'd21);
        end
`endif

        // FIFO full for five cycles after two words of a burst
        doReset(1);
        for (int k = 0; k < 8; k++) prod_q[1].push_back(8'(8'h20 + k));
        applyStimulus();
        repeat (3) tick("stall");
        full_sig = 1'b1;
        applyStimulus();
        n_before = write_log.size();
        repeat (5) tick("stall_full");
        checkEq("stall_nowrite", 32'(write_log.size()), 32'(n_before));
        checkEq("stall_held", 32'(bus.busy), 32'd1);
        checkEq("stall_grants", 32'(grant_log.size()), 32'd1);
        full_sig = 1'b0;
        applyStimulus();
        repeat (2) tick("stall_resume");
        checkEq("stall_count", 32'(write_log.size()), 32'd4);
        checkEq("stall_ended", 32'(bus.busy), 32'd0);
        repeat (8) tick("stall_drain");
        checkEq("stall_total", 32'(write_log.size()), 32'd8);
        for (int k = 0; k < 8 && k < write_log.size(); k++)
            checkEq("stall_word", 32'(write_log[k]), 32'(8'h20 + k));

        // Owner releases after one word, with FIFO full in the release cycle
        doReset(1);
        prod_q[1] = '{8'h30};
        prod_q[3] = '{8'h40, 8'h41};
        applyStimulus();
        repeat (2) tick("rel");
        full_sig = 1'b1;
        applyStimulus();
        tick("rel_full");
        checkEq("rel_idle", 32'(bus.busy), 32'd0);
        full_sig = 1'b0;
        applyStimulus();
        repeat (5) tick("rel_next");
        checkEq("rel_count", 32'(write_log.size()), 32'd3);
        exp_a = '{8'h30, 8'h40, 8'h41, 0, 0, 0};
        for (int k = 0; k < 3 && k < write_log.size(); k++)
            checkEq("rel_word", 32'(write_log[k]), 32'(exp_a[k]));
        checkEq("rel_grants", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() == 2) begin
            checkEq("rel_g0", 32'(grant_log[0]), 32'd1);
            checkEq("rel_g1", 32'(grant_log[1]), 32'd3);
        end

`ifdef FIFO_ARB_FIXED_PRIO_EN
        // Producers 0 and 3 always offering: producer 0 keeps winning
        doReset(1);
        for (int k = 0; k < 40; k++) prod_q[0].push_back(8'(k));
        for (int k = 0; k < 10; k++) prod_q[3].push_back(8'(8'h80 + k));
        applyStimulus();
        repeat (30) tick("fixed");
        checkEq("fixed_grants", 32'(grant_log.size() >= 5), 32'd1);
        foreach (grant_log[g]) checkEq("fixed_owner", 32'(grant_log[g]), 32'd0);
`endif

        // Randomized traffic with random FIFO full and occasional resets
        doReset(1);
        rand_en = 1'b1;
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < NUM_REQ; i++)
                if (prod_q[i].size() < 4 && $urandom_range(0, 2) == 0)
                    prod_q[i].push_back(8'($urandom));
            full_sig = ($urandom_range(0, 3) == 0);
            rst_sig  = ($urandom_range(0, 149) == 0);
            applyStimulus();
            tick("rand");
        end
        rand_en  = 1'b0;
        full_sig = 1'b0;
        rst_sig  = 1'b0;

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end
endmodule
